// File: rtl/calc_pkg.sv
// Shared types and project defaults for the 16-bit signed calculator datapath.
package calc_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } mem_state_e;

  localparam int CALC_DATA_W    = 16;
  localparam int CALC_MEM_DEPTH = 16;

  // Even parity: the returned bit makes the XOR of data plus parity equal to zero.
  function automatic logic even_parity(input logic [CALC_DATA_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/calc_mem_clear.sv
// Clear sequencer for calc_mem: sweeps every word to zero after reset or on a clr
// request, one word per cycle, and reports busy while doing so.
module calc_mem_clear
  import calc_pkg::*;
#(
  parameter int DEPTH  = CALC_MEM_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  output logic              busy,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              clr_we
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  mem_state_e        state;
  mem_state_e        state_next;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // The counter wraps back to 0 on leaving CLEAR so a later clr starts clean.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      CLEAR: begin
        if (cnt == LAST) begin
          state_next = READY;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      READY: begin
        if (clr) begin
          state_next = CLEAR;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = CLEAR;
        cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    busy     = (state == CLEAR);
    clr_we   = (state == CLEAR);
    clr_addr = cnt;
  end

endmodule

// File: rtl/calc_mem.sv
// Operand/result store: single-port RAM with clear sequencer, registered read and
// oe-gated read bus. Define CALC_MEM_PARITY_EN to add per-word even parity checking.
module calc_mem
  import calc_pkg::*;
#(
  parameter int DATA_W = CALC_DATA_W,
  parameter int DEPTH  = CALC_MEM_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              cs,
  input  logic              we,
  input  logic              oe,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy
`ifdef CALC_MEM_PARITY_EN
  ,
  output logic              parity_err
`endif
);

`ifdef CALC_MEM_PARITY_EN
  localparam int WORD_W = DATA_W + 1;
`else
  localparam int WORD_W = DATA_W;
`endif

  localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DEPTH);

  logic [WORD_W-1:0] mem [DEPTH];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              in_range;
  logic              accept;
  logic              rd_accept;
  logic              wr_accept;
  logic [WORD_W-1:0] wr_word;
  logic [WORD_W-1:0] rd_word;
  logic [DATA_W-1:0] rd_reg;

  calc_mem_clear #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clear (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .busy     (busy),
    .clr_addr (clr_addr),
    .clr_we   (clr_we)
  );

  // clr takes priority over a same-cycle access, and nothing is accepted while busy.
  always_comb begin
    in_range  = ({1'b0, addr} < LIMIT);
    accept    = cs && !busy && !clr;
    rd_accept = accept && !we;
    wr_accept = accept && we && in_range;
`ifdef CALC_MEM_PARITY_EN
    wr_word   = {^wr_data, wr_data};
`else
    wr_word   = wr_data;
`endif
    rd_word   = in_range ? mem[addr] : '0;
  end

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_accept) begin
      mem[addr] <= wr_word;
    end
  end

  // The read register survives a clr; only reset or a new read replaces it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_reg   <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_accept;
      if (rd_accept) begin
        rd_reg <= rd_word[DATA_W-1:0];
      end
    end
  end

`ifdef CALC_MEM_PARITY_EN
  // Out-of-range reads see an all-zero word, which always has good parity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_err <= 1'b0;
    end else begin
      parity_err <= rd_accept && (^rd_word);
    end
  end
`endif

  assign rd_data = oe ? rd_reg : '0;

endmodule

// File: tb/tb_calc_mem.sv
// Scoreboard bench for calc_mem: a 16-word and a 10-word instance share random
// stimulus; a word-level reference model predicts reads, busy windows and rd_data.
module tb_calc_mem;

  typedef struct packed {
    logic [15:0] data;
    logic        perr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        cs = 1'b0;
  logic        we = 1'b0;
  logic        oe = 1'b0;
  logic [3:0]  addr = '0;
  logic [15:0] wr_data = '0;

  logic [15:0] rd16, rd10;
  logic        rv16, rv10, busy16, busy10;
  logic        pe16, pe10;

  int checks = 0;
  int failures = 0;

  int          mem_m [2][16];
  bit          flip_m [2][16];
  int          busy_left [2];
  logic [15:0] held [2];
  exp_t        q0 [$];
  exp_t        q1 [$];

  always #5 clk = ~clk;

  calc_mem #(.DATA_W(16), .DEPTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .cs(cs), .we(we), .oe(oe),
    .addr(addr), .wr_data(wr_data), .rd_data(rd16), .rd_valid(rv16), .busy(busy16)
`ifdef CALC_MEM_PARITY_EN
    , .parity_err(pe16)
`endif
  );

  calc_mem #(.DATA_W(16), .DEPTH(10)) dut10 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .cs(cs), .we(we), .oe(oe),
    .addr(addr), .wr_data(wr_data), .rd_data(rd10), .rd_valid(rv10), .busy(busy10)
`ifdef CALC_MEM_PARITY_EN
    , .parity_err(pe10)
`endif
  );

`ifndef CALC_MEM_PARITY_EN
  assign pe16 = 1'b0;
  assign pe10 = 1'b0;
`endif

  function automatic int depth_of(input int d);
    return (d == 0) ? 16 : 10;
  endfunction

  function automatic void zero_model(input int d);
    for (int i = 0; i < 16; i++) begin
      mem_m[d][i]  = 0;
      flip_m[d][i] = 1'b0;
    end
  endfunction

  function automatic void push_exp(input int d, input exp_t e);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  function automatic exp_t pop_exp(input int d);
    return (d == 0) ? q0.pop_front() : q1.pop_front();
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Behaviour of one rising edge with reset released: clears absorb the next
  // DEPTH edges, clr wins over access, out-of-range writes vanish and reads give 0.
  function automatic void model_edge();
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (busy_left[d] > 0) begin
        busy_left[d]--;
      end else if (clr) begin
        zero_model(d);
        busy_left[d] = depth_of(d);
      end else if (cs && we) begin
        if (int'(addr) < depth_of(d)) begin
          mem_m[d][addr]  = int'(wr_data);
          flip_m[d][addr] = 1'b0;
        end
      end else if (cs) begin
        if (int'(addr) < depth_of(d)) begin
          e.data = mem_m[d][addr][15:0];
          e.perr = flip_m[d][addr];
        end else begin
          e.data = 16'h0000;
          e.perr = 1'b0;
        end
        push_exp(d, e);
      end
    end
  endfunction

  task automatic apply_stimulus(input logic c, input logic w, input logic [3:0] a,
                                input logic [15:0] data, input logic cl, input logic o);
    cs = c; we = w; addr = a; wr_data = data; clr = cl; oe = o;
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) apply_stimulus(1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 1'b1);
  endtask

  task automatic reset_pulse(input int n);
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      zero_model(d);
      busy_left[d] = depth_of(d);
      held[d]      = 16'h0000;
    end
    idle(n);
    rst_n = 1'b1;
  endtask

  task automatic check_output(input int d, input logic b, input logic rv,
                              input logic [15:0] rd, input logic pe);
    string tag;
    exp_t  e;
    tag = (d == 0) ? "d16" : "d10";
    check({tag, " busy"}, {31'd0, b}, {31'd0, busy_left[d] > 0});
    if (rv) begin
      if (qsize(d) == 0) begin
        check({tag, " unexpected rd_valid"}, 32'd1, 32'd0);
      end else begin
        e = pop_exp(d);
        held[d] = e.data;
        check({tag, " rd_data"}, {16'd0, rd}, {16'd0, oe ? e.data : 16'h0000});
        check({tag, " parity_err"}, {31'd0, pe}, {31'd0, e.perr});
      end
    end else begin
      check({tag, " held rd_data"}, {16'd0, rd}, {16'd0, oe ? held[d] : 16'h0000});
      check({tag, " idle parity_err"}, {31'd0, pe}, 32'd0);
    end
  endtask

  always @(negedge clk) begin
    check_output(0, busy16, rv16, rd16, pe16);
    check_output(1, busy10, rv10, rd10, pe10);
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      zero_model(d);
      busy_left[d] = depth_of(d);
      held[d]      = 16'h0000;
    end
    reset_pulse(3);
    idle(18);

    // Fill with garbage, then reset: the sweep must leave every word zero.
    for (int i = 0; i < 16; i++)
      apply_stimulus(1'b1, 1'b1, 4'(i), 16'($urandom), 1'b0, 1'b1);
    idle(1);
    reset_pulse(2);
    idle(17);
    apply_stimulus(1'b1, 1'b0, 4'd5, 16'h0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++)
      apply_stimulus(1'b1, 1'b0, 4'(i), 16'h0, 1'b0, 1'b1);

    // Basic access, then the same read with oe low, then oe back high.
    apply_stimulus(1'b1, 1'b1, 4'd3, 16'h8001, 1'b0, 1'b1);
    apply_stimulus(1'b1, 1'b0, 4'd3, 16'h0, 1'b0, 1'b1);
    idle(1);
    apply_stimulus(1'b1, 1'b0, 4'd3, 16'h0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 1'b0);
    idle(2);

    // clr with a simultaneous write, then writes attempted during busy.
    apply_stimulus(1'b1, 1'b1, 4'd4, 16'h5555, 1'b0, 1'b1);
    apply_stimulus(1'b1, 1'b1, 4'd4, 16'h1234, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++)
      apply_stimulus(1'b1, 1'b1, 4'd6, 16'h1234, 1'b0, 1'b1);
    apply_stimulus(1'b1, 1'b0, 4'd6, 16'h0, 1'b1, 1'b1);
    idle(14);
    apply_stimulus(1'b1, 1'b0, 4'd4, 16'h0, 1'b0, 1'b1);
    apply_stimulus(1'b1, 1'b0, 4'd6, 16'h0, 1'b0, 1'b1);

    // Addresses beyond the 10-word instance.
    apply_stimulus(1'b1, 1'b1, 4'd12, 16'hBEEF, 1'b0, 1'b1);
    apply_stimulus(1'b1, 1'b0, 4'd12, 16'h0, 1'b0, 1'b1);
    apply_stimulus(1'b1, 1'b1, 4'd15, 16'hCAFE, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++)
      apply_stimulus(1'b1, 1'b0, 4'(i), 16'h0, 1'b0, 1'b1);
    idle(1);

    // Reset in the middle of a sweep restarts it.
    reset_pulse(1);
    idle(7);
    reset_pulse(1);
    idle(17);

`ifdef CALC_MEM_PARITY_EN
    apply_stimulus(1'b1, 1'b1, 4'd2, 16'h00F1, 1'b0, 1'b1);
    apply_stimulus(1'b1, 1'b1, 4'd3, 16'h0F0F, 1'b0, 1'b1);
    idle(1);
    dut16.mem[2][16] = ~dut16.mem[2][16];
    dut10.mem[2][16] = ~dut10.mem[2][16];
    flip_m[0][2] = 1'b1;
    flip_m[1][2] = 1'b1;
    apply_stimulus(1'b1, 1'b0, 4'd2, 16'h0, 1'b0, 1'b1);
    apply_stimulus(1'b1, 1'b0, 4'd3, 16'h0, 1'b0, 1'b1);
    apply_stimulus(1'b1, 1'b0, 4'd2, 16'h0, 1'b0, 1'b0);
    idle(2);
`endif

    for (int i = 0; i < 600; i++) begin
      apply_stimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                     4'($urandom_range(0, 15)), 16'($urandom),
                     1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 3) != 0));
    end
    idle(20);

    check("d16 pending reads", q0.size(), 32'd0);
    check("d10 pending reads", q1.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
